// File: rtl/fp_normalizer_if.sv
// Handshake and data bundle for fp_normalizer.
// master: the side that supplies adder results and consumes normalized ones.
// slave:  the normalizer itself.
interface fp_normalizer_if;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [27:0] mantis_in;
  logic        out_valid;
  logic        out_ready;
  logic        sign_out;
  logic [7:0]  exp_out;
  logic [27:0] mantis_out;
  logic        overflow;

  modport master (
    output in_valid, sign_in, exp_in, mantis_in, out_ready,
    input  in_ready, out_valid, sign_out, exp_out, mantis_out, overflow
  );

  modport slave (
    input  in_valid, sign_in, exp_in, mantis_in, out_ready,
    output in_ready, out_valid, sign_out, exp_out, mantis_out, overflow
  );
endinterface

// File: rtl/fp_normalizer.sv
// Floating-point post-add normalizer: IDLE -> SHIFT -> DONE -> IDLE.
// Mantissa layout: bit 27 carry, bit 26 hidden bit, bits 2:0 guard/round/sticky.
// Optional macro FP_NORMALIZER_LZC_EN: normalize with a leading-zero count in a
// single SHIFT cycle instead of one bit per cycle. Results are identical.
module fp_normalizer (
  input logic           clk,
  input logic           rst,
  fp_normalizer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e      state_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        sign_q;
  logic [7:0]  exp_q;
  logic [27:0] mant_q;
  logic        ovf_q;

  // Result of one SHIFT-state edge.
  logic [7:0]  step_exp;
  logic [27:0] step_mant;
  logic        step_ovf;
  logic        step_done;

`ifdef FP_NORMALIZER_LZC_EN
  logic [4:0]  lz;
  logic [7:0]  limit;
  logic [7:0]  sh;

  // Leading zeros above the first set bit of a 27-bit field (27 if all zero).
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] res;
    logic       found;
    res   = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        res   = 5'(26 - i);
        found = 1'b1;
      end
    end
    return res;
  endfunction
`endif

  // Next working values for the current SHIFT edge.
  always_comb begin
    step_exp  = exp_q;
    step_mant = mant_q;
    step_ovf  = 1'b0;
    step_done = 1'b1;
`ifdef FP_NORMALIZER_LZC_EN
    lz    = lzc27(mant_q[26:0]);
    limit = 8'd0;
    sh    = 8'd0;
`endif
    if (mant_q[27]) begin
      // Carry out: single right shift, dropped bit folds into sticky.
      if (exp_q >= 8'd254) begin
        step_exp  = 8'd255;
        step_mant = 28'd0;
        step_ovf  = 1'b1;
      end else begin
        step_exp  = exp_q + 8'd1;
        step_mant = {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
      end
    end else if (mant_q == 28'd0) begin
      step_exp = 8'd0;
    end else if (mant_q[26]) begin
      step_exp = exp_q;
    end else if (exp_q <= 8'd1) begin
      // No exponent room left: subnormal, mantissa untouched.
      step_exp = 8'd0;
    end else begin
`ifdef FP_NORMALIZER_LZC_EN
      limit     = exp_q - 8'd1;
      sh        = ({3'b000, lz} > limit) ? limit : {3'b000, lz};
      step_mant = mant_q << sh;
      step_exp  = step_mant[26] ? (exp_q - sh) : 8'd0;
`else
      step_mant = {mant_q[26:0], 1'b0};
      step_exp  = exp_q - 8'd1;
      if (step_mant[26]) begin
        step_done = 1'b1;
      end else if (exp_q == 8'd2) begin
        // Reached exp 1 without a hidden bit: report as subnormal.
        step_exp  = 8'd0;
        step_done = 1'b1;
      end else begin
        step_done = 1'b0;
      end
`endif
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sign_q      <= 1'b0;
      exp_q       <= 8'd0;
      mant_q      <= 28'd0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.in_valid && in_ready_q) begin
            sign_q     <= bus.sign_in;
            exp_q      <= bus.exp_in;
            mant_q     <= bus.mantis_in;
            ovf_q      <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= StShift;
          end
        end
        StShift: begin
          exp_q  <= step_exp;
          mant_q <= step_mant;
          ovf_q  <= step_ovf;
          if (step_done) begin
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.sign_out   = sign_q;
  assign bus.exp_out    = exp_q;
  assign bus.mantis_out = mant_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_fp_normalizer.sv
// Self-checking bench for fp_normalizer: reference model from the normalization
// rules, a per-cycle output compare process, and directed vectors.
module tb_fp_normalizer;

  logic clk;
  logic rst;
  fp_normalizer_if bus ();

  fp_normalizer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Expected result of the operation currently in flight.
  logic        exp_sign;
  logic [7:0]  exp_exp;
  logic [27:0] exp_mant;
  logic        exp_ovf;
  int          exp_lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: position of the leading one decides how far to shift; the
  // exponent may only drop to 1, otherwise the result is reported subnormal.
  task automatic model(input logic s, input logic [7:0] e, input logic [27:0] m,
                       output logic os, output logic [7:0] oe, output logic [27:0] om,
                       output logic ov, output int lat);
    int msb, need, avail, sh, ne;
    os  = s;
    ov  = 1'b0;
    lat = 1;
    if (m[27]) begin
      ne = int'(e) + 1;
      if (ne >= 255) begin
        oe = 8'd255;
        om = 28'd0;
        ov = 1'b1;
      end else begin
        oe = 8'(ne);
        om = (m >> 1) | {27'd0, m[0]};
      end
    end else if (m == 28'd0) begin
      oe = 8'd0;
      om = 28'd0;
    end else begin
      msb = 0;
      for (int i = 0; i < 27; i++) if (m[i]) msb = i;
      need  = 26 - msb;
      avail = (e > 8'd1) ? int'(e) - 1 : 0;
      sh    = (need < avail) ? need : avail;
      om    = m << sh;
      oe    = (sh == need) ? 8'(int'(e) - sh) : 8'd0;
`ifndef FP_NORMALIZER_LZC_EN
      lat = (sh > 1) ? sh : 1;
`endif
    end
  endtask

  // Whenever a result is presented it must match the model and block input.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      chk("sign_out", 32'(bus.sign_out), 32'(exp_sign));
      chk("exp_out", 32'(bus.exp_out), 32'(exp_exp));
      chk("mantis_out", 32'(bus.mantis_out), 32'(exp_mant));
      chk("overflow", 32'(bus.overflow), 32'(exp_ovf));
      chk("in_ready_in_done", 32'(bus.in_ready), 32'd0);
    end
  end

  task automatic start_op(input logic s, input logic [7:0] e, input logic [27:0] m);
    @(negedge clk);
    model(s, e, m, exp_sign, exp_exp, exp_mant, exp_ovf, exp_lat);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.sign_in   = s;
    bus.exp_in    = e;
    bus.mantis_in = m;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_op(input logic s, input logic [7:0] e, input logic [27:0] m,
                        input int hold);
    int lat;
    start_op(s, e, m);
    lat = 0;
    while (!bus.out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    if (!bus.out_valid) return;
    // Stall downstream while hammering the input side.
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.sign_in   = ~s;
      bus.exp_in    = 8'hAA;
      bus.mantis_in = 28'h4000000 | 28'($urandom_range(0, 1000));
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("released_out_valid", 32'(bus.out_valid), 32'd0);
    chk("released_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
    chk({tag, "_sign"}, 32'(bus.sign_out), 32'd0);
    chk({tag, "_exp"}, 32'(bus.exp_out), 32'd0);
    chk({tag, "_mant"}, 32'(bus.mantis_out), 32'd0);
  endtask

  initial begin
    logic        ps;
    logic [7:0]  pe;
    logic [27:0] pm;
    logic        pv;
    int          pl;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.sign_in   = 1'b0;
    bus.exp_in    = 8'd0;
    bus.mantis_in = 28'd0;
    bus.out_ready = 1'b0;
    exp_sign = 1'b0; exp_exp = 8'd0; exp_mant = 28'd0; exp_ovf = 1'b0; exp_lat = 1;

    // Pin the model with hand-computed values.
    model(1'b0, 8'd100, 28'h0400000, ps, pe, pm, pv, pl);
    chk("model_shift4_exp", 32'(pe), 32'd96);
    chk("model_shift4_mant", 32'(pm), 32'h4000000);
`ifdef FP_NORMALIZER_LZC_EN
    chk("model_shift4_lat", 32'(pl), 32'd1);
`else
    chk("model_shift4_lat", 32'(pl), 32'd4);
`endif
    model(1'b0, 8'd10, 28'h8000003, ps, pe, pm, pv, pl);
    chk("model_carry_exp", 32'(pe), 32'd11);
    chk("model_carry_mant", 32'(pm), 32'h4000001);
    model(1'b0, 8'd254, 28'h8000000, ps, pe, pm, pv, pl);
    chk("model_ovf", {pv, pe, 4'd0, pm[19:0]}, {1'b1, 8'd255, 24'd0});
    model(1'b0, 8'd3, 28'h0000100, ps, pe, pm, pv, pl);
    chk("model_subn", {pe, pm}, {8'd0, 28'h0000400});
    model(1'b1, 8'd77, 28'h0, ps, pe, pm, pv, pl);
    chk("model_zero", {ps, pe, pm}, {1'b1, 8'd0, 28'd0});

    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;

    run_op(1'b0, 8'd100, 28'h0400000, 0);   // four left shifts
    run_op(1'b0, 8'd10,  28'h8000003, 0);   // carry, sticky kept
    run_op(1'b0, 8'd254, 28'h8000000, 0);   // overflow to 255
    run_op(1'b0, 8'd3,   28'h0000100, 0);   // stops at exp 1, subnormal
    run_op(1'b1, 8'd77,  28'h0000000, 0);   // zero mantissa
    run_op(1'b1, 8'd50,  28'h4000005, 0);   // already normalized
    run_op(1'b0, 8'd20,  28'h0001000, 5);   // downstream stall
    run_op(1'b0, 8'd200, 28'h0000001, 0);   // deepest shift
    run_op(1'b0, 8'd5,   28'h0000001, 0);   // exponent runs out mid-shift
    run_op(1'b1, 8'd1,   28'h0000010, 0);   // no room at all
    run_op(1'b0, 8'd255, 28'h8000001, 0);   // carry from max exponent

    // Reset in the middle of a multi-cycle shift.
    start_op(1'b0, 8'd100, 28'h0400000);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_state("midreset");
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b0, 8'd100, 28'h0400000, 2);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
